// File: rtl/nios_sys_cache_reader_pkg.sv
// Shared definitions for the cache reader: FSM state encodings and the fixed
// read latency of the dual-port buffer's s2 port.
package nios_sys_cache_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/nios_sys_cache_reader_fifo.sv
// Small synchronous FIFO that absorbs the buffer's read latency so downstream
// backpressure never drops a word. Head word is presented combinationally.
module nios_sys_cache_reader_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/nios_sys_cache_reader.sv
// Avalon-MM read master for the buffer's s2 port: reads word_count words from
// base_addr and streams them out with valid/ready, credit-limited by the FIFO.
module nios_sys_cache_reader
  import nios_sys_cache_reader_pkg::*;
#(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic                m_clken,
  input  logic [DATA_W-1:0]   m_readdata,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam int              CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] ONE   = (ADDR_W + 1)'(1);

  state_t            state;
  logic [ADDR_W:0]   word_count_q;
  logic [ADDR_W:0]   issue_cnt;
  logic [ADDR_W:0]   pop_cnt;
  logic [ADDR_W:0]   last_idx;
  logic              rd_pending;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;

  assign m_write      = 1'b0;
  assign m_byteenable = '1;
  assign m_clken      = 1'b1;

  // A read still in flight owns a FIFO slot, so the FIFO can never overflow.
  assign last_idx     = word_count_q - ONE;
  assign credit_used  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rd_pending};
  assign m_chipselect = (state == ISSUE) && !fifo_full &&
                        (credit_used < (CNT_W + 1)'(FIFO_DEPTH));

  assign busy      = (state == ISSUE) || (state == DRAIN);
  assign done      = (state == DONE);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_last  = out_valid && (pop_cnt == last_idx);

  nios_sys_cache_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_pending),
    .push_data (m_readdata),
    .pop       (pop),
    .pop_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      m_address    <= '0;
      word_count_q <= '0;
      issue_cnt    <= '0;
      pop_cnt      <= '0;
      rd_pending   <= 1'b0;
    end else begin
      rd_pending <= m_chipselect;
      if (pop) pop_cnt <= pop_cnt + ONE;
      unique case (state)
        IDLE: begin
          if (start) begin
            m_address    <= base_addr;
            word_count_q <= word_count;
            issue_cnt    <= '0;
            pop_cnt      <= '0;
            state        <= (word_count == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (m_chipselect) begin
            m_address <= m_address + ADDR_W'(1);
            issue_cnt <= issue_cnt + ONE;
            if (issue_cnt == last_idx) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && (pop_cnt == last_idx)) state <= DONE;
        end
        DONE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nios_sys_cache_reader.sv
// Self-checking bench for nios_sys_cache_reader: a buffer model feeds the DUT
// and every streamed word is compared with the buffer contents at base+index.
module tb_nios_sys_cache_reader;

  localparam int MEM_WORDS = 512;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  base_addr = '0;
  logic [9:0]  word_count = '0;
  logic        busy;
  logic        done;
  logic [8:0]  m_address;
  logic        m_chipselect;
  logic        m_write;
  logic [3:0]  m_byteenable;
  logic        m_clken;
  logic [31:0] m_readdata = '0;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;

  logic [31:0] mem [MEM_WORDS];

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  // Job bookkeeping shared between the stimulus and the stream monitor
  bit          job_active = 1'b0;
  int          job_base, job_count, job_mode;
  int          issued, accepted, done_cnt, done_cycle, first_acc, last_acc;
  bit          hold_pending = 1'b0;
  logic [31:0] hold_data;

  nios_sys_cache_reader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .m_address    (m_address),
    .m_chipselect (m_chipselect),
    .m_write      (m_write),
    .m_byteenable (m_byteenable),
    .m_clken      (m_clken),
    .m_readdata   (m_readdata),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer model: q is valid one cycle after the read strobe
  always @(posedge clk) begin
    if (m_chipselect) m_readdata <= mem[m_address];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stream monitor: picks out_ready for the coming edge, then checks what that edge will do
  always @(negedge clk) begin
    if (!job_active) begin
      out_ready = 1'b1;
    end else begin
      case (job_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (hold_pending) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", out_data, hold_data);
      end
      hold_pending = out_valid && !out_ready;
      hold_data    = out_data;
      if (job_count == 0) begin
        checkOutput("zero_cs", 32'(m_chipselect), 32'd0);
        checkOutput("zero_valid", 32'(out_valid), 32'd0);
      end
      if (m_chipselect) begin
        checkOutput("credit", 32'((issued - accepted) < 4), 32'd1);
        checkOutput("overissue", 32'(issued < job_count), 32'd1);
        checkOutput("addr", 32'(m_address), 32'((job_base + issued) % MEM_WORDS));
        issued++;
      end
      if (out_valid)
        checkOutput("last", 32'(out_last), 32'(accepted == job_count - 1));
      if (out_valid && out_ready) begin
        checkOutput("data", out_data, mem[(job_base + accepted) % MEM_WORDS]);
        if (accepted == 0) first_acc = cyc;
        last_acc = cyc;
        accepted++;
      end
      if (done) begin
        done_cnt++;
        done_cycle = cyc;
      end
    end
  end

  task automatic beginJob(input int b, input int n, input int mode);
    @(negedge clk);
    job_base     = b;
    job_count    = n;
    job_mode     = mode;
    issued       = 0;
    accepted     = 0;
    done_cnt     = 0;
    done_cycle   = -1;
    first_acc    = -1;
    last_acc     = -1;
    hold_pending = 1'b0;
    job_active   = 1'b1;
    base_addr    = b[8:0];
    word_count   = n[9:0];
    start        = 1'b1;
  endtask

  task automatic applyStimulus(input int b, input int n, input int mode, input bit restart);
    int waited;
    int start_cyc;
    bit got_done;
    beginJob(b, n, mode);
    start_cyc = cyc;
    waited    = 0;
    got_done  = 1'b0;
    while (!got_done && waited < 3000) begin
      @(negedge clk);
      start = 1'b0;
      waited++;
      if (restart && (waited == 3 || waited == 6)) begin
        start      = 1'b1;
        base_addr  = 9'd200;
        word_count = 10'd5;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    checkOutput("done_seen", 32'(got_done), 32'd1);
    if (n == 0) checkOutput("zero_done_lat", 32'(waited <= 2), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("words", 32'(accepted), 32'(n));
    checkOutput("issued", 32'(issued), 32'(n));
    checkOutput("done_cnt", 32'(done_cnt), 32'd1);
    checkOutput("busy_idle", 32'(busy), 32'd0);
    if (n > 0 && mode == 0) begin
      checkOutput("stream_gap", 32'(last_acc - first_acc), 32'(n - 1));
      checkOutput("first_lat", 32'((first_acc - start_cyc) <= 3), 32'd1);
      checkOutput("done_after_last", 32'(done_cycle - last_acc), 32'd1);
    end
    job_active = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_cs"}, 32'(m_chipselect), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_last"}, 32'(out_last), 32'd0);
    checkOutput({tag, "_addr"}, 32'(m_address), 32'd0);
  endtask

  initial begin
    int w;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'(i * 3);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkResetOutputs("reset");
    checkOutput("m_write", 32'(m_write), 32'd0);
    checkOutput("byteen", 32'(m_byteenable), 32'hF);
    checkOutput("clken", 32'(m_clken), 32'd1);
    reset_n = 1'b1;

    applyStimulus(5, 8, 0, 1'b0);
    applyStimulus(510, 4, 0, 1'b0);
    applyStimulus(0, 16, 1, 1'b0);
    applyStimulus(37, 16, 2, 1'b0);
    applyStimulus(100, 0, 0, 1'b0);
    applyStimulus(5, 8, 0, 1'b1);

    // Abort a job after three words have been taken
    beginJob(20, 8, 0);
    w = 0;
    while (accepted < 3 && w < 200) begin
      @(negedge clk);
      start = 1'b0;
      w++;
    end
    checkOutput("abort_progress", 32'(accepted >= 3), 32'd1);
    #2;
    job_active = 1'b0;
    reset_n    = 1'b0;
    #1;
    checkResetOutputs("abort");
    @(negedge clk);
    checkResetOutputs("abort_hold");
    reset_n = 1'b1;
    applyStimulus(0, 2, 0, 1'b0);

    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
      applyStimulus(int'($urandom_range(0, 511)), int'($urandom_range(1, 40)), 2, 1'b0);
    end
    applyStimulus(300, 512, 2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
